// File: rtl/lu_mem_stream_reader_pkg.sv
// rtl/lu_mem_stream_reader_pkg.sv - shared widths, RAM depth and FSM states for the LU stream reader
package lu_solver_pkg;

  localparam int LU_ADDR_W = 13;
  localparam int LU_DATA_W = 32;
  localparam int LU_BE_W   = LU_DATA_W / 8;
  localparam int RAM_DEPTH = 1 << LU_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lu_state_e;

endpackage

// File: rtl/lu_mem_stream_reader_if.sv
// rtl/lu_mem_stream_reader_if.sv - RAM read bus plus ready/valid output stream
interface lu_mem_stream_reader_if
  import lu_solver_pkg::*;
#(
  parameter int ADDR_W = LU_ADDR_W,
  parameter int DATA_W = LU_DATA_W,
  parameter int BE_W   = LU_BE_W
);

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/lu_skid_fifo2.sv
// rtl/lu_skid_fifo2.sv - two-entry FIFO of {last, data}; flush wins over push/pop
module lu_skid_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o
);

  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        last_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign do_push     = push_i & (cnt_q != 2'd2);
  assign do_pop      = pop_i & (cnt_q != 2'd0);
  assign count_o     = cnt_q;
  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/lu_mem_stream_reader.sv
// rtl/lu_mem_stream_reader.sv - reads word_count RAM words from base_addr and streams them out in order
module lu_mem_stream_reader
  import lu_solver_pkg::*;
#(
  parameter int ADDR_W = LU_ADDR_W,
  parameter int DATA_W = LU_DATA_W,
  parameter int BE_W   = LU_BE_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [ADDR_W:0]        word_count_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  lu_mem_stream_reader_if.master bus
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  lu_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              out_valid;
  logic              pop;
  logic              kill;
  logic              issue;
  logic [2:0]        occ;

  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & bus.out_ready;
  assign kill      = abort_i & (state_q != IDLE);
  // Room check counts the word already in flight, so the FIFO can never be overrun.
  assign occ       = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == RUN) & ~abort_i & (rd_idx_q < count_q) & (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    inflight_d  = issue;
    infl_last_d = issue & (rd_idx_q == count_q - ONE);
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (word_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            base_d   = base_addr_i;
            count_d  = (word_count_i > DEPTH) ? DEPTH : word_count_i;
            rd_idx_d = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (issue) rd_idx_d = rd_idx_q + ONE;
          if (rd_idx_q == count_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (kill) begin
          state_d = IDLE;
        end else if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      rd_idx_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  // The RAM returns q one cycle after issue; inflight_q marks that cycle.
  lu_skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (bus.mem_readdata),
    .push_last_i (infl_last_q),
    .pop_i       (pop),
    .flush_i     (kill),
    .count_o     (fifo_cnt),
    .head_data_o (head_data),
    .head_last_o (head_last)
  );

  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign bus.mem_address    = base_q + rd_idx_q[ADDR_W-1:0];
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = {BE_W{1'b1}};
  assign bus.mem_clken      = 1'b1;
  assign bus.out_data       = head_data;
  assign bus.out_valid      = out_valid;
  assign bus.out_last       = head_last & out_valid;

endmodule

// File: tb/tb_lu_mem_stream_reader.sv
// tb/tb_lu_mem_stream_reader.sv - directed bench for lu_mem_stream_reader with a RAM model
module tb_lu_mem_stream_reader;
  import lu_solver_pkg::*;

  localparam int AW = LU_ADDR_W;
  localparam int DW = LU_DATA_W;
  localparam int BW = LU_BE_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy;
  logic          done;

  lu_mem_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

  lu_mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [RAM_DEPTH];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clk) ram_addr_q <= bus.mem_address;
  assign bus.mem_readdata = ram[ram_addr_q];

  int total = 0;
  int bad = 0;
  int cs_cnt, done_cnt, hold_err, max_occ, cyc, last_hs_cyc, done_cyc, last_cnt, occ;
  bit busy_seen, busy_at_done, prev_stall, prev_abort, prev_last, toggle;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] addr_log [$];
  logic [DW-1:0] rx_data [$];
  bit rx_last [$];
  bit [3:0] patt = 4'b1001;
  int n;

  always @(negedge clk) begin
    #3;
    cyc++;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.mem_chipselect) begin
        cs_cnt++;
        addr_log.push_back(bus.mem_address);
      end
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.out_data);
        rx_last.push_back(bus.out_last);
        if (bus.out_last) begin
          last_cnt++;
          last_hs_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (busy) busy_seen = 1'b1;
      occ = int'(dut.fifo_cnt) + int'(dut.inflight_q);
      if (occ > max_occ) max_occ = occ;
      if (prev_stall && !prev_abort &&
          (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        hold_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      prev_abort = abort;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear_mon();
    cs_cnt = 0; done_cnt = 0; hold_err = 0; max_occ = 0; last_cnt = 0;
    busy_seen = 1'b0; busy_at_done = 1'b0;
    last_hs_cyc = -1; done_cyc = -1;
    addr_log.delete(); rx_data.delete(); rx_last.delete();
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] wc);
    base_addr = b;
    word_count = wc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      if (toggle) bus.out_ready = patt[k % 4];
      k++;
    end
    chk({tag, "_timeout"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic chk_words(input string tag, input int num, input logic [DW-1:0] first);
    chk({tag, "_nwords"}, 64'(rx_data.size()), 64'(num));
    for (int i = 0; i < num && i < rx_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(rx_data[i]), 64'(first + DW'(i)));
      chk($sformatf("%s_last%0d", tag, i), 64'(rx_last[i]), 64'(i == num - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = DW'(32'h1000 + i);
    bus.out_ready = 1'b1;
    toggle = 1'b0;
    clear_mon();

    // Reset values while reset_n is held low
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cs", 64'(bus.mem_chipselect), 64'd0);
    chk("rst_addr", 64'(bus.mem_address), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("const_write", 64'(bus.mem_write), 64'd0);
    chk("const_be", 64'(bus.mem_byteenable), 64'hF);
    chk("const_clken", 64'(bus.mem_clken), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic read with latency checks
    clear_mon();
    pulse_start(13'h010, 14'd4);
    #1;
    chk("basic_cs_t1", 64'(bus.mem_chipselect), 64'd1);
    chk("basic_addr_t1", 64'(bus.mem_address), 64'h010);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_valid_t1", 64'(bus.out_valid), 64'd0);
    @(negedge clk); #1;
    chk("basic_valid_t2m", 64'(bus.out_valid), 64'd0);
    @(negedge clk); #1;
    chk("basic_valid_t2", 64'(bus.out_valid), 64'd1);
    chk("basic_data_t2", 64'(bus.out_data), 64'h1010);
    wait_done(1, 40, "basic");
    chk_words("basic", 4, 32'h1010);
    chk("basic_cs_cnt", 64'(cs_cnt), 64'd4);
    chk("basic_done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
    chk("basic_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure with out_ready pattern 1,0,0,1
    clear_mon();
    pulse_start(13'h000, 14'd8);
    toggle = 1'b1;
    wait_done(1, 200, "bp");
    toggle = 1'b0;
    bus.out_ready = 1'b1;
    chk_words("bp", 8, 32'h1000);
    chk("bp_hold", 64'(hold_err), 64'd0);
    chk("bp_occ", 64'(max_occ <= 2), 64'd1);
    chk("bp_cs_cnt", 64'(cs_cnt), 64'd8);

    // Address wrap past the top of the RAM
    clear_mon();
    pulse_start(13'h1FFE, 14'd4);
    wait_done(1, 40, "wrap");
    chk("wrap_naddr", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", 64'(addr_log[0]), 64'h1FFE);
      chk("wrap_a1", 64'(addr_log[1]), 64'h1FFF);
      chk("wrap_a2", 64'(addr_log[2]), 64'h0000);
      chk("wrap_a3", 64'(addr_log[3]), 64'h0001);
    end
    chk("wrap_nwords", 64'(rx_data.size()), 64'd4);
    if (rx_data.size() == 4) begin
      chk("wrap_d0", 64'(rx_data[0]), 64'h2FFE);
      chk("wrap_d1", 64'(rx_data[1]), 64'h2FFF);
      chk("wrap_d2", 64'(rx_data[2]), 64'h1000);
      chk("wrap_d3", 64'(rx_data[3]), 64'h1001);
    end

    // Zero count
    clear_mon();
    pulse_start(13'h055, 14'd0);
    #1;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("zero_done_off", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_cs", 64'(cs_cnt), 64'd0);
    chk("zero_busy_seen", 64'(busy_seen), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Saturated count, then a back-to-back start on the done cycle
    clear_mon();
    pulse_start(13'h000, 14'h3FFF);
    n = 0;
    while (!done && n < 9000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("sat_timeout", 64'(done), 64'd1);
    chk("sat_nwords", 64'(rx_data.size()), 64'd8192);
    chk("sat_cs_cnt", 64'(cs_cnt), 64'd8192);
    chk("sat_lasts", 64'(last_cnt), 64'd1);
    if (rx_data.size() == 8192) begin
      chk("sat_first", 64'(rx_data[0]), 64'h1000);
      chk("sat_final", 64'(rx_data[8191]), 64'h2FFF);
      chk("sat_final_last", 64'(rx_last[8191]), 64'd1);
    end
    clear_mon();
    pulse_start(13'h020, 14'd2);
    #1;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(2, 40, "b2b");
    chk_words("b2b", 2, 32'h1020);

    // Abort while stalled
    clear_mon();
    bus.out_ready = 1'b0;
    pulse_start(13'h040, 14'd16);
    repeat (4) @(negedge clk);
    chk("abort_cs_limit", 64'(cs_cnt), 64'd2);
    chk("abort_full_valid", 64'(bus.out_valid), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_cs", 64'(bus.mem_chipselect), 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_no_words", 64'(rx_data.size()), 64'd0);
    bus.out_ready = 1'b1;
    clear_mon();
    pulse_start(13'h100, 14'd2);
    wait_done(1, 40, "post_abort");
    chk_words("post_abort", 2, 32'h1100);
    chk("post_abort_cs", 64'(cs_cnt), 64'd2);

    // Asynchronous reset mid-transfer
    clear_mon();
    pulse_start(13'h200, 14'd16);
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cs", 64'(bus.mem_chipselect), 64'd0);
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_data", 64'(bus.out_data), 64'd0);
    chk("arst_last", 64'(bus.out_last), 64'd0);
    chk("arst_addr", 64'(bus.mem_address), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_mon();
    pulse_start(13'h300, 14'd3);
    wait_done(1, 40, "post_rst");
    chk_words("post_rst", 3, 32'h1300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
